// File: rtl/sine_pkg.sv
// Shared types and constants for the sine serial arbiter.
package sine_pkg;

  localparam int unsigned FRAME_BITS = 8;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StShift,
    StGap
  } state_e;

endpackage

// File: rtl/sine_serial_arbiter_if.sv
// Requester handshake and serial output bundle of the sine serial arbiter.
interface sine_serial_arbiter_if;

  logic       req0;
  logic       req1;
  logic [7:0] data0;
  logic [7:0] data1;
  logic       ack0;
  logic       ack1;
  logic       chan;
  logic       busy;
  logic       soc;
  logic       SI_en;
  logic       SO;

  modport master (
    output req0, req1, data0, data1,
    input  ack0, ack1, chan, busy, soc, SI_en, SO
  );

  modport slave (
    input  req0, req1, data0, data1,
    output ack0, ack1, chan, busy, soc, SI_en, SO
  );

endinterface

// File: rtl/tick_gen.sv
// Bit-rate divider: one-clk tick every TICK_DIV enabled clocks; count freezes when disabled.
module tick_gen #(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_enable,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (tick_enable) begin
      cnt_q <= (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = tick_enable && (cnt_q == CntLast);

endmodule

// File: rtl/sine_serial_arbiter.sv
// Two-requester round-robin arbiter that serialises the granted byte as a
// START / 8 data bits / GAP frame, one bit period per divider tick.
module sine_serial_arbiter
  import sine_pkg::*;
#(
  parameter int unsigned TICK_DIV = 10
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic                  tick_enable,
  sine_serial_arbiter_if.slave bus
);

  logic       tick;
  state_e     state_q;
  logic [7:0] sreg_q;
  logic [2:0] bit_cnt_q;
  logic       last_q;
  logic       chan_q;
  logic       busy_q;
  logic       soc_q;
  logic       si_en_q;
  logic       so_q;
  logic       win;
  logic       grant;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_enable(tick_enable),
    .tick       (tick)
  );

  // Contention goes to the channel not served last; a lone requester always wins.
  always_comb begin
    win   = bus.req1;
    grant = 1'b0;
    if (bus.req0 && bus.req1) begin
      win = ~last_q;
    end
    if (rst_n && tick && (state_q == StIdle || state_q == StGap)) begin
      grant = bus.req0 || bus.req1;
    end
  end

  assign bus.ack0 = grant && !win;
  assign bus.ack1 = grant && win;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      last_q    <= 1'b1;
      chan_q    <= 1'b0;
      busy_q    <= 1'b0;
      soc_q     <= 1'b0;
      si_en_q   <= 1'b0;
      so_q      <= 1'b0;
    end else if (tick) begin
      unique case (state_q)
        StIdle, StGap: begin
          si_en_q <= 1'b0;
          so_q    <= 1'b0;
          if (grant) begin
            state_q <= StStart;
            sreg_q  <= win ? bus.data1 : bus.data0;
            chan_q  <= win;
            last_q  <= win;
            busy_q  <= 1'b1;
            soc_q   <= 1'b1;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            soc_q   <= 1'b0;
          end
        end
        StStart: begin
          state_q   <= StShift;
          soc_q     <= 1'b0;
          si_en_q   <= 1'b1;
          so_q      <= sreg_q[7];
          bit_cnt_q <= '0;
        end
        StShift: begin
          sreg_q    <= {sreg_q[6:0], 1'b0};
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(FRAME_BITS - 1)) begin
            state_q <= StGap;
            si_en_q <= 1'b0;
            so_q    <= 1'b0;
          end else begin
            so_q <= sreg_q[6];
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.chan  = chan_q;
  assign bus.busy  = busy_q;
  assign bus.soc   = soc_q;
  assign bus.SI_en = si_en_q;
  assign bus.SO    = so_q;

endmodule

// File: tb/tb_sine_serial_arbiter.sv
// Self-checking bench: frames are checked as whole transactions (grant channel,
// soc/SI_en/busy lengths, recovered byte) against a round-robin reference model.
module tb_sine_serial_arbiter;

  localparam int unsigned TDIV = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic tick_enable;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   last_served = 1;

  sine_serial_arbiter_if bus_if ();

  sine_serial_arbiter #(
    .TICK_DIV(TDIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_enable(tick_enable),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int winner(input logic r0, input logic r1);
    if (r0 && r1) return (last_served == 1) ? 0 : 1;
    return r1 ? 1 : 0;
  endfunction

  task automatic wait_ack(output int ch, output int waited);
    waited = 0;
    while (!(bus_if.ack0 || bus_if.ack1) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (bus_if.ack0 && bus_if.ack1) ch = 2;
    else if (bus_if.ack0)           ch = 0;
    else if (bus_if.ack1)           ch = 1;
    else                            ch = -1;
  endtask

  // Samples the 10 bit periods following a grant; optional freeze window mid-frame.
  task automatic capture(input int ch, input logic [7:0] post_data, input bit hold,
                         input int freeze_at, output logic [7:0] rx, output int soc_n,
                         output int si_n, output int busy_n, output int bad_n,
                         output int frz_bad);
    logic [3:0] held;
    rx = 8'h00; soc_n = 0; si_n = 0; busy_n = 0; bad_n = 0; frz_bad = 0;
    for (int i = 0; i < 10 * TDIV; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (!hold) begin
          bus_if.req0 = 1'b0;
          bus_if.req1 = 1'b0;
        end
        if (ch == 1) bus_if.data1 = post_data;
        else         bus_if.data0 = post_data;
      end
      soc_n  += int'(bus_if.soc);
      busy_n += int'(bus_if.busy);
      if (bus_if.chan !== ch[0]) bad_n++;
      if (i < 10 * TDIV - 1 && (bus_if.ack0 || bus_if.ack1)) bad_n++;
      if (bus_if.SI_en) begin
        if (si_n % TDIV == 0) rx = {rx[6:0], bus_if.SO};
        si_n++;
      end else if (bus_if.SO !== 1'b0) begin
        bad_n++;
      end
      if (i == freeze_at) begin
        held = {bus_if.SO, bus_if.SI_en, bus_if.soc, bus_if.busy};
        tick_enable = 1'b0;
        repeat (20) begin
          @(negedge clk);
          if ({bus_if.SO, bus_if.SI_en, bus_if.soc, bus_if.busy} !== held) frz_bad++;
        end
        tick_enable = 1'b1;
      end
    end
  endtask

  task automatic run_frame(input string tag, input int exp_ch, input logic [7:0] exp_data,
                           input logic [7:0] post_data, input bit hold, input int freeze_at,
                           input int max_wait);
    int ch, w, s, si, b, bad, fb;
    logic [7:0] rx;
    #1;
    wait_ack(ch, w);
    check({tag, "_ack_chan"}, ch, exp_ch);
    check({tag, "_ack_wait_ok"}, (w <= max_wait) ? 32'd1 : 32'd0, 32'd1);
    capture(exp_ch, post_data, hold, freeze_at, rx, s, si, b, bad, fb);
    check({tag, "_soc_clks"}, s, TDIV);
    check({tag, "_si_en_clks"}, si, 8 * TDIV);
    check({tag, "_busy_clks"}, b, 10 * TDIV);
    check({tag, "_data"}, {24'h0, rx}, {24'h0, exp_data});
    check({tag, "_glitches"}, bad, 0);
    if (freeze_at >= 0) check({tag, "_freeze_stable"}, fb, 0);
    last_served = exp_ch;
  endtask

  initial begin
    int         ch, w, act;
    logic [7:0] d0, d1;
    int         p, e;

    rst_n = 1'b0;
    tick_enable = 1'b1;
    bus_if.req0 = 1'b0;
    bus_if.req1 = 1'b0;
    bus_if.data0 = 8'h00;
    bus_if.data1 = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs", {25'h0, bus_if.ack0, bus_if.ack1, bus_if.chan, bus_if.busy,
          bus_if.soc, bus_if.SI_en, bus_if.SO}, 32'h0);
    rst_n = 1'b1;
    last_served = 1;
    repeat (2) @(negedge clk);

    // Both requesters held: ch0 first after reset, then alternate with no idle gap.
    bus_if.data0 = 8'h01;
    bus_if.data1 = 8'h80;
    bus_if.req0 = 1'b1;
    bus_if.req1 = 1'b1;
    run_frame("rr0", winner(1'b1, 1'b1), 8'h01, 8'h01, 1'b1, -1, TDIV);
    run_frame("rr1", winner(1'b1, 1'b1), 8'h80, 8'h80, 1'b1, -1, 0);
    run_frame("rr2", winner(1'b1, 1'b1), 8'h01, 8'h01, 1'b1, -1, 0);
    bus_if.req0 = 1'b0;
    bus_if.req1 = 1'b0;
    repeat (8) @(negedge clk);

    bus_if.data0 = 8'hA5;
    bus_if.req0 = 1'b1;
    run_frame("a5", 0, 8'hA5, 8'h3C, 1'b0, -1, TDIV);
    repeat (8) @(negedge clk);

    bus_if.data0 = 8'hFF;
    bus_if.req0 = 1'b1;
    run_frame("late_data", 0, 8'hFF, 8'h00, 1'b0, -1, TDIV);
    repeat (8) @(negedge clk);

    d1 = 8'($urandom);
    bus_if.data1 = d1;
    bus_if.req1 = 1'b1;
    run_frame("freeze", 1, d1, ~d1, 1'b0, 14, TDIV);
    repeat (8) @(negedge clk);

    // Reset at the first clk of data bit 4.
    bus_if.data0 = 8'($urandom);
    bus_if.req0 = 1'b1;
    #1;
    wait_ack(ch, w);
    check("rst_frame_ack_chan", ch, 0);
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      if (i == 0) bus_if.req0 = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_served = 1;
    #1;
    check("mid_frame_reset", {25'h0, bus_if.ack0, bus_if.ack1, bus_if.chan, bus_if.busy,
          bus_if.soc, bus_if.SI_en, bus_if.SO}, 32'h0);

    // req1 high for two clks, dropped before the first tick after reset.
    bus_if.data1 = 8'h5A;
    bus_if.req1 = 1'b1;
    act = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (i == 1) bus_if.req1 = 1'b0;
      act += int'(bus_if.ack0 | bus_if.ack1 | bus_if.soc | bus_if.SI_en | bus_if.busy |
                  bus_if.SO);
    end
    check("short_req_no_frame", act, 0);

    d0 = 8'($urandom);
    bus_if.data0 = d0;
    bus_if.req0 = 1'b1;
    run_frame("post_reset", 0, d0, 8'($urandom), 1'b0, -1, TDIV);

    for (int k = 0; k < 12; k++) begin
      repeat ($urandom_range(0, 6)) @(negedge clk);
      p  = int'($urandom_range(0, 2));
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      bus_if.data0 = d0;
      bus_if.data1 = d1;
      bus_if.req0 = (p != 1);
      bus_if.req1 = (p != 0);
      e = winner(bus_if.req0, bus_if.req1);
      run_frame("rnd", e, (e == 1) ? d1 : d0, 8'($urandom), 1'b0, -1, TDIV);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sine_serial_arbiter.md
SINE_SERIAL_ARBITER -- requirements
Module: sine_serial_arbiter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 10, meaning clk cycles per serial bit period (legal range 2..1024).
REQ-002 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-004 SHALL have port tick_enable, input, 1, bit-rate divider run enable.
REQ-005 SHALL have ports req0 / req1, input, 1 each, requester frame request, level, held until ack.
REQ-006 SHALL have ports data0 / data1, input, 8 each, requester sample, valid while req high.
REQ-007 SHALL have ports ack0 / ack1, output, 1 each, one-clk grant pulse; data sampled that cycle.
REQ-008 SHALL have port chan, output, 1, channel of frame in flight (0 = req0), held for the whole frame.
REQ-009 SHALL have port busy, output, 1, high from grant until the end of the GAP state.
REQ-010 SHALL have port soc, output, 1, start-of-conversion strobe, high for one full bit period.
REQ-011 SHALL have port SI_en, output, 1, serial data enable, high during the 8 data bit periods.
REQ-012 SHALL have port SO, output, 1, serial data, MSB first.

Function
REQ-013 Divider SHALL count 0..TICK_DIV-1; tick pulses for one clk when count = TICK_DIV-1 and tick_enable = 1.
REQ-014 Divider count SHALL freeze while tick_enable = 0; no tick, FSM frozen, outputs held.
REQ-015 FSM SHALL have states IDLE, START, SHIFT, GAP; all transitions occur only on tick.
REQ-016 In IDLE, or in GAP on tick, with any req high, SHALL grant in that same clk: pulse ackN, load shift register with dataN, set chan, go to START.
REQ-017 If no req is high, IDLE SHALL remain IDLE; GAP SHALL go to IDLE.
REQ-018 Arbitration SHALL be round-robin: with req0 and req1 both high, grant the channel not served last; a single requester is always granted.
REQ-019 A req deasserted before its ack SHALL cause no grant and no frame.
REQ-020 START SHALL last one bit period with soc = 1, SO = 0, SI_en = 0; on tick go to SHIFT, bit counter = 0.
REQ-021 SHIFT SHALL drive SI_en = 1 and SO = shift-register bit 7; each tick shifts left one bit and increments the 3-bit counter.
REQ-022 On the tick with counter = 7, SHIFT SHALL go to GAP; exactly 8 bit periods of SI_en per frame.
REQ-023 GAP SHALL last one bit period with soc = SI_en = SO = 0.
REQ-024 A frame is 10 bit periods (START + 8 + GAP); back-to-back frames have no extra idle period.
REQ-025 Requester data changes after ack SHALL NOT affect the frame in flight.
REQ-026 soc, SI_en, SO, chan and busy SHALL be registered outputs, glitch-free.

Reset
REQ-027 With rst_n = 0 at a clk edge: FSM = IDLE, divider count = 0, bit counter = 0, shift register = 0, round-robin pointer = last-served 1 (req0 wins first contention).
REQ-028 Reset values: ack0 = ack1 = 0, chan = 0, busy = 0, soc = 0, SI_en = 0, SO = 0.
REQ-029 Reset asserted mid-frame SHALL abort it with no further SO/SI_en activity and no pending grant retained.

Structure
REQ-030 Shared package sine_pkg SHALL hold the FSM state type and the constant FRAME_BITS = 8.
REQ-031 The bit-rate divider SHALL be a sub-module named tick_gen (ports clk, rst_n, tick_enable, tick; parameter TICK_DIV).
REQ-032 Implementation size: 120-400 lines of RTL.

Verification (TICK_DIV = 4, 100 MHz clk)
REQ-033 req0 = 1, data0 = 8'hA5 from IDLE -> ack0 at next tick, soc high for 4 clk, then SO = 1,0,1,0,0,1,0,1 with SI_en high for 32 clk, then 4 clk GAP, chan = 0.
REQ-034 req0 and req1 both held high with data 8'h01 / 8'h80 -> frames alternate ch0, ch1, ch0, each 40 clk, no idle between frames.
REQ-035 tick_enable low for 20 clk mid-SHIFT -> SO, SI_en and bit position frozen; the frame resumes and completes with correct data.
REQ-036 rst_n low for 1 clk at bit 4 of a frame -> next clk all outputs 0 and FSM IDLE; the next req0 is granted normally.
REQ-037 req1 pulsed high 2 clk between ticks -> no ack1 and no frame.
REQ-038 data0 changed from 8'hFF to 8'h00 one clk after ack0 -> SO carries 8'hFF.
